// File: rtl/pipeline_pkg.sv
// Shared instruction-format constants and issue-action encoding for the
// pipeline front end.
package pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_AW  = 5;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ACT_IDLE   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_ISSUE  = 2'd2
  } issue_act_e;

  function automatic logic [REG_AW-1:0] rs_of(input logic [INSTR_W-1:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [REG_AW-1:0] rt_of(input logic [INSTR_W-1:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

  function automatic logic [REG_AW-1:0] rd_of(input logic [INSTR_W-1:0] instr);
    return instr[RD_HI:RD_LO];
  endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// Loader-side handshake plus the issue outputs feeding Pipeline.InstrIn.
interface instr_issue_unit_if
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_out;
  logic               issued;
  logic               bubble;
  logic               empty;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output in_valid, in_instr,
    input  in_ready, instr_out, issued, bubble, empty, bubble_cnt
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, instr_out, issued, bubble, empty, bubble_cnt
  );

endinterface

// File: rtl/instr_fifo.sv
// Small instruction FIFO with a combinational head; full/empty come from the
// occupancy counter so pointer equality never has to be disambiguated.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Issues one instruction per clock from the FIFO, inserting NOP bubbles while
// the head reads a register written by one of the last HAZ_WIN issued slots.
module instr_issue_unit
  import pipeline_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  instr_issue_unit_if.slave  bus
);

  logic [INSTR_W-1:0]              head;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [$clog2(DEPTH):0]          fifo_count;
  logic                            fifo_pop;

  logic [HAZ_WIN-1:0][REG_AW-1:0]  hist_reg;
  logic [HAZ_WIN-1:0]              match;
  logic                            hazard;
  logic [REG_AW-1:0]               head_rs;
  logic [REG_AW-1:0]               head_rt;

  issue_act_e                      act;
  logic [INSTR_W-1:0]              instr_out_reg;
  logic [INSTR_W-1:0]              instr_out_next;
  logic                            issued_reg;
  logic                            bubble_reg;
  logic [CNT_W-1:0]                bubble_cnt_reg;
  logic [REG_AW-1:0]               hist_in;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .din   (bus.in_instr),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_rs = rs_of(head);
  assign head_rt = rt_of(head);

  // R0 is hardwired zero, so a zero source never waits on anything.
  genvar gi;
  generate
    for (gi = 0; gi < HAZ_WIN; gi++) begin : g_cmp
      assign match[gi] = ((head_rs != '0) && (head_rs == hist_reg[gi])) ||
                         ((head_rt != '0) && (head_rt == hist_reg[gi]));
    end
  endgenerate

  assign hazard = |match;

  always_comb begin
    act = ACT_IDLE;
    if (!fifo_empty) act = hazard ? ACT_BUBBLE : ACT_ISSUE;
  end

  always_comb begin
    fifo_pop       = 1'b0;
    instr_out_next = NOP_INSTR;
    hist_in        = '0;
    if (act == ACT_ISSUE) begin
      fifo_pop       = 1'b1;
      instr_out_next = head;
      hist_in        = rd_of(head);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_out_reg  <= NOP_INSTR;
      issued_reg     <= 1'b0;
      bubble_reg     <= 1'b0;
      bubble_cnt_reg <= '0;
      hist_reg       <= '0;
    end else begin
      instr_out_reg <= instr_out_next;
      issued_reg    <= (act == ACT_ISSUE);
      bubble_reg    <= (act == ACT_BUBBLE);
      if ((act == ACT_BUBBLE) && (bubble_cnt_reg != '1))
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      hist_reg[0] <= hist_in;
      for (int i = 1; i < HAZ_WIN; i++) hist_reg[i] <= hist_reg[i-1];
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.empty      = (fifo_count == '0);
  assign bus.instr_out  = instr_out_reg;
  assign bus.issued     = issued_reg;
  assign bus.bubble     = bubble_reg;
  assign bus.bubble_cnt = bubble_cnt_reg;

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
Producer-side front end for the 5-stage Pipeline's InstrIn port. Buffers R-type instructions from a loader in a small FIFO and issues one instruction per clock into the pipeline. Inserts all-zero NOP bubbles on read-after-write hazards against recently issued destinations, and emits NOPs when idle. Sits between the instruction source (testbench or loader) and Pipeline.InstrIn.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
HAZ_WIN, 3, number of previously issued slots whose rd is checked against the head's rs/rt
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
in_valid  in  1  loader presents in_instr
in_instr  in  32  instruction: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:0] unused
in_ready  out  1  FIFO can accept; equals !full
instr_out  out  32  registered instruction to Pipeline.InstrIn
issued  out  1  1-cycle pulse: instr_out holds a real FIFO instruction this cycle
bubble  out  1  1-cycle pulse: instr_out is a hazard NOP this cycle
empty  out  1  FIFO occupancy == 0
bubble_cnt  out  CNT_W  saturating count of hazard bubbles since reset

Behaviour:
- Reset (rst=0, async): FIFO pointers and occupancy = 0; history cleared to all 0; instr_out = 32'h0; issued = 0; bubble = 0; bubble_cnt = 0; empty = 1; in_ready = 1.
- Push: at a rising edge with in_valid && in_ready. in_ready depends only on full; there is no same-cycle push-while-full, even if a pop occurs.
- Latency: a word pushed into an empty FIFO at edge N can be issued at edge N+1 and is visible on instr_out after edge N+1. No bypass.
- Each edge, exactly one of three actions:
  1) Empty: instr_out <= 0; issued = 0; bubble = 0; shift 0 into history.
  2) Hazard: head.rs or head.rt is nonzero and equals any history entry -> instr_out <= 0; bubble = 1; head stays; shift 0 into history; bubble_cnt += 1, saturating at all-ones.
  3) Otherwise: pop head; instr_out <= head; issued = 1; shift head.rd into history.
- History is a HAZ_WIN-deep shift register of 5-bit rd values, with the newest at index 0.
  - R0 never creates or matches a hazard.
  - An all-zero input word is a legal instruction: it issues as a real instruction with rd = 0 and sets issued = 1.
- Hazard window: a dependent instruction following its producer sees exactly HAZ_WIN bubbles if issued back-to-back. Each intervening independent issue reduces that count by one.
- Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
- Pointers wrap modulo DEPTH. Full is derived from the occupancy counter (width clog2(DEPTH)+1), not from pointer equality.
- Reset mid-stream discards all buffered instructions and history. instr_out goes to 0 immediately, asynchronously.
- issued and bubble are never both 1.

Decomposition:
- Package pipeline_pkg holds:
  - field slice constants (OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO)
  - REG_AW = 5
  - INSTR_W = 32
  - NOP_INSTR = 32'h0
- One sub-module, instr_fifo: parameterised DEPTH/width, with push/pop/full/empty/head/count.
- Hazard compare and history shift register stay in instr_issue_unit.

Test Plan:
- Reset, then push 0x00411000 (rs2 rt1 rd2), 0x00832000 (rs4 rt3 rd4), 0x00C53000 (rs6 rt5 rd6) on consecutive cycles -> instr_out shows the three words on consecutive cycles starting one cycle after the first push; issued = 1,1,1; bubble_cnt = 0.
- Push 0x00411000 then 0x00432800 (rs2 rt3 rd5), HAZ_WIN=3 -> 0x00411000, then 3 NOP cycles with bubble = 1, then 0x00432800; bubble_cnt = 3.
- Push 0x00411000, 0x00832000, 0x00432800 -> second word issues with no gap; dependent third word sees 2 bubbles; bubble_cnt = 2.
- Fill FIFO with 4 words while hazard-stalled -> in_ready = 0 after the 4th push; a 5th in_valid is ignored; words drain in order after the stall clears, with no loss or duplication.
- Assert rst=0 mid-stream with 2 words buffered -> instr_out = 0 without waiting for a clock edge; empty = 1; after release, instr_out stays 0 and nothing stale issues.
- Push instructions with rs = rt = 0 following rd = 0 producers -> no bubbles; push 0x00000000 -> issued = 1 with instr_out = 0.
